// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencer for the 5-stage RV32 pipeline.
// Produces per-cycle HOLD/FLUSH controls for the PC and pipeline registers
// from load-use hazards, taken branches and IMEM/DMEM wait states, and keeps
// saturating stall/flush counters plus a sticky DMEM timeout flag.
module pipeline_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [4:0]       ID_RS1,
  input  logic [4:0]       ID_RS2,
  input  logic             ID_USES_RS1,
  input  logic             ID_USES_RS2,
  input  logic             EX_MEM_READ,
  input  logic [4:0]       EX_RD,
  input  logic             EX_BRANCH_TAKEN,
  input  logic             IMEM_BUSY,
  input  logic             DMEM_BUSY,
  output logic             PC_HOLD,
  output logic             IF_ID_HOLD,
  output logic             ID_EX_HOLD,
  output logic             EX_MEM_HOLD,
  output logic             IF_ID_FLUSH,
  output logic             ID_EX_FLUSH,
  output logic             MEM_WB_FLUSH,
  output logic             MEM_ERR,
  output logic [CNT_W-1:0] STALL_CNT,
  output logic [CNT_W-1:0] FLUSH_CNT
);

  localparam int BUSY_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_DRAIN    = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic              drain_pend_reg, drain_pend_next;
  logic [BUSY_W-1:0] busy_cnt_reg;
  logic              mem_err_reg;
  logic [CNT_W-1:0]  stall_cnt_reg;
  logic [CNT_W-1:0]  flush_cnt_reg;
  logic              load_use;
  logic              draining;
  logic              branch_evt;

  // A load in EX feeding a source register read in ID; x0 never hazards.
  assign load_use = EX_MEM_READ && (EX_RD != 5'd0) &&
                    ((ID_USES_RS1 && (ID_RS1 == EX_RD)) ||
                     (ID_USES_RS2 && (ID_RS2 == EX_RD)));

  // The cycle DMEM releases behaves like the state the freeze interrupted.
  assign draining = (state_reg == ST_DRAIN) ||
                    ((state_reg == ST_MEM_WAIT) && drain_pend_reg);

  // Next-state and control outputs, highest-priority condition first.
  always_comb begin
    state_next      = state_reg;
    drain_pend_next = drain_pend_reg;
    branch_evt      = 1'b0;
    PC_HOLD         = 1'b0;
    IF_ID_HOLD      = 1'b0;
    ID_EX_HOLD      = 1'b0;
    EX_MEM_HOLD     = 1'b0;
    IF_ID_FLUSH     = 1'b0;
    ID_EX_FLUSH     = 1'b0;
    MEM_WB_FLUSH    = 1'b0;
    if (!RESET_N) begin
      // Bubble every register while reset is asserted.
      IF_ID_FLUSH  = 1'b1;
      ID_EX_FLUSH  = 1'b1;
      MEM_WB_FLUSH = 1'b1;
    end else if (DMEM_BUSY) begin
      // Freeze everything upstream of MEM, feed bubbles into WB.
      PC_HOLD      = 1'b1;
      IF_ID_HOLD   = 1'b1;
      ID_EX_HOLD   = 1'b1;
      EX_MEM_HOLD  = 1'b1;
      MEM_WB_FLUSH = 1'b1;
      state_next   = ST_MEM_WAIT;
      if (state_reg == ST_DRAIN) begin
        drain_pend_next = 1'b1;
      end
    end else begin
      drain_pend_next = 1'b0;
      if (EX_BRANCH_TAKEN) begin
        IF_ID_FLUSH = 1'b1;
        ID_EX_FLUSH = 1'b1;
        branch_evt  = 1'b1;
        // A fetch still in flight belongs to the wrong path and must drain.
        state_next  = IMEM_BUSY ? ST_DRAIN : ST_RUN;
      end else if (draining) begin
        // ID holds a flushed bubble here, so load-use cannot apply.
        if (IMEM_BUSY) begin
          PC_HOLD     = 1'b1;
          IF_ID_FLUSH = 1'b1;
          state_next  = ST_DRAIN;
        end else begin
          state_next  = ST_RUN;
        end
      end else begin
        state_next = ST_RUN;
        if (load_use) begin
          PC_HOLD     = 1'b1;
          IF_ID_HOLD  = 1'b1;
          ID_EX_FLUSH = 1'b1;
        end else if (IMEM_BUSY) begin
          PC_HOLD     = 1'b1;
          IF_ID_FLUSH = 1'b1;
        end
      end
    end
  end

  // FSM state and pending-drain flag.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg      <= ST_RUN;
      drain_pend_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      drain_pend_reg <= drain_pend_next;
    end
  end

  // Consecutive DMEM busy tracking and sticky timeout flag.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      busy_cnt_reg <= '0;
      mem_err_reg  <= 1'b0;
    end else if (DMEM_BUSY) begin
      if (busy_cnt_reg != BUSY_W'(MEM_TIMEOUT)) begin
        busy_cnt_reg <= busy_cnt_reg + BUSY_W'(1);
      end
      if (busy_cnt_reg == BUSY_W'(MEM_TIMEOUT - 1)) begin
        mem_err_reg <= 1'b1;
      end
    end else begin
      busy_cnt_reg <= '0;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (PC_HOLD && (stall_cnt_reg != {CNT_W{1'b1}})) begin
        stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
      end
      if (branch_evt && (flush_cnt_reg != {CNT_W{1'b1}})) begin
        flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
      end
    end
  end

  assign MEM_ERR   = mem_err_reg;
  assign STALL_CNT = stall_cnt_reg;
  assign FLUSH_CNT = flush_cnt_reg;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed scenarios followed by random traffic, checked
// every cycle against a behavioural model that tracks only a "stale fetch in
// flight" flag, a busy-run length and plain integer counters.
module tb_pipeline_ctrl;

  localparam int TO  = 4;
  localparam int CW  = 6;
  localparam int SAT = (1 << CW) - 1;

  logic          CLK = 1'b0;
  logic          RESET_N = 1'b1;
  logic [4:0]    ID_RS1 = '0, ID_RS2 = '0, EX_RD = '0;
  logic          ID_USES_RS1 = 0, ID_USES_RS2 = 0, EX_MEM_READ = 0;
  logic          EX_BRANCH_TAKEN = 0, IMEM_BUSY = 0, DMEM_BUSY = 0;
  logic          PC_HOLD, IF_ID_HOLD, ID_EX_HOLD, EX_MEM_HOLD;
  logic          IF_ID_FLUSH, ID_EX_FLUSH, MEM_WB_FLUSH, MEM_ERR;
  logic [CW-1:0] STALL_CNT, FLUSH_CNT;

  pipeline_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .ID_RS1(ID_RS1), .ID_RS2(ID_RS2),
    .ID_USES_RS1(ID_USES_RS1), .ID_USES_RS2(ID_USES_RS2),
    .EX_MEM_READ(EX_MEM_READ), .EX_RD(EX_RD),
    .EX_BRANCH_TAKEN(EX_BRANCH_TAKEN), .IMEM_BUSY(IMEM_BUSY), .DMEM_BUSY(DMEM_BUSY),
    .PC_HOLD(PC_HOLD), .IF_ID_HOLD(IF_ID_HOLD), .ID_EX_HOLD(ID_EX_HOLD),
    .EX_MEM_HOLD(EX_MEM_HOLD), .IF_ID_FLUSH(IF_ID_FLUSH), .ID_EX_FLUSH(ID_EX_FLUSH),
    .MEM_WB_FLUSH(MEM_WB_FLUSH), .MEM_ERR(MEM_ERR),
    .STALL_CNT(STALL_CNT), .FLUSH_CNT(FLUSH_CNT)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  // Reference model state
  bit       m_stale;      // a wrong-path fetch is still outstanding
  int       m_busy_run;
  bit       m_err;
  int       m_stall;
  int       m_flush;
  // Per-cycle model results
  // ctrl bits: {PC_HOLD, IF_ID_HOLD, ID_EX_HOLD, EX_MEM_HOLD, IF_ID_FLUSH, ID_EX_FLUSH, MEM_WB_FLUSH}
  logic [6:0] exp_ctrl;
  bit         exp_branch;
  bit         exp_stale_next;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_stale = 0; m_busy_run = 0; m_err = 0; m_stall = 0; m_flush = 0;
  endtask

  task automatic model_eval();
    bit lu;
    exp_ctrl = 7'b0; exp_branch = 0; exp_stale_next = m_stale;
    lu = EX_MEM_READ && (EX_RD != 0) &&
         ((ID_USES_RS1 && ID_RS1 == EX_RD) || (ID_USES_RS2 && ID_RS2 == EX_RD));
    if (!RESET_N)             exp_ctrl = 7'b0000111;
    else if (DMEM_BUSY)       exp_ctrl = 7'b1111001;
    else if (EX_BRANCH_TAKEN) begin
      exp_ctrl = 7'b0000110; exp_branch = 1; exp_stale_next = IMEM_BUSY;
    end else if (m_stale) begin
      if (IMEM_BUSY) exp_ctrl = 7'b1000100;
      else           exp_stale_next = 0;
    end else if (lu)          exp_ctrl = 7'b1100010;
    else if (IMEM_BUSY)       exp_ctrl = 7'b1000100;
  endtask

  task automatic model_commit();
    if (DMEM_BUSY) begin
      m_busy_run++;
      if (m_busy_run >= TO) m_err = 1;
    end else begin
      m_busy_run = 0;
    end
    m_stale = exp_stale_next;
    if (exp_ctrl[6]) m_stall = (m_stall + 1 > SAT) ? SAT : m_stall + 1;
    if (exp_branch)  m_flush = (m_flush + 1 > SAT) ? SAT : m_flush + 1;
  endtask

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                       input logic u2, input logic ld, input logic [4:0] rd,
                       input logic br, input logic ib, input logic db);
    ID_RS1 = rs1; ID_RS2 = rs2; ID_USES_RS1 = u1; ID_USES_RS2 = u2;
    EX_MEM_READ = ld; EX_RD = rd; EX_BRANCH_TAKEN = br; IMEM_BUSY = ib; DMEM_BUSY = db;
  endtask

  task automatic idle();
    drive(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0);
  endtask

  // One clock: check controls mid-cycle, then registered state after the edge.
  task automatic do_cycle(input string tag);
    model_eval();
    @(negedge CLK);
    chk({tag, ".ctrl"}, {25'd0, PC_HOLD, IF_ID_HOLD, ID_EX_HOLD, EX_MEM_HOLD,
                         IF_ID_FLUSH, ID_EX_FLUSH, MEM_WB_FLUSH}, {25'd0, exp_ctrl});
    @(posedge CLK);
    if (RESET_N) model_commit();
    #1;
    chk({tag, ".stall"}, {26'd0, STALL_CNT}, m_stall);
    chk({tag, ".flush"}, {26'd0, FLUSH_CNT}, m_flush);
    chk({tag, ".err"},   {31'd0, MEM_ERR},   {31'd0, m_err});
  endtask

  initial begin
    int burst;
    model_reset();
    idle();
    #2 RESET_N = 1'b0;
    do_cycle("reset");
    do_cycle("reset");
    RESET_N = 1'b1;
    do_cycle("idle");

    // load x5 in EX, ID reads rs2 = x5 -> single bubble
    drive(5'd1, 5'd5, 1, 1, 1, 5'd5, 0, 0, 0);
    do_cycle("loaduse");
    chk("loaduse.stall_one", {26'd0, STALL_CNT}, 32'd1);
    idle();
    do_cycle("after_lu");

    // x0 load never hazards
    drive(5'd0, 5'd3, 1, 0, 1, 5'd0, 0, 0, 0);
    do_cycle("x0");
    chk("x0.nostall", {26'd0, STALL_CNT}, 32'd1);
    drive(5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, 0);
    do_cycle("branch");
    chk("branch.flush_one", {26'd0, FLUSH_CNT}, 32'd1);

    // branch with IMEM busy for 3 cycles -> drain
    drive(5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 1, 0);
    do_cycle("drain0");
    drive(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0);
    do_cycle("drain1");
    do_cycle("drain2");
    idle();
    do_cycle("drain_exit");
    do_cycle("drain_run");

    // DMEM busy 4 cycles with concurrent branch and load-use
    for (int i = 0; i < 4; i++) begin
      drive(5'd7, 5'd0, 1, 0, 1, 5'd7, 1, 0, 1);
      do_cycle("freeze");
    end
    drive(5'd7, 5'd0, 1, 0, 1, 5'd7, 0, 0, 0);
    do_cycle("post_freeze_lu");
    idle();
    do_cycle("post_freeze");

    // Timeout: 6 busy cycles, error from the 4th onward
    RESET_N = 1'b0;
    model_reset();
    do_cycle("rst2");
    RESET_N = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      drive(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 1);
      do_cycle("timeout");
      if (i == 3) chk("timeout.before", {31'd0, MEM_ERR}, 32'd0);
      if (i == 4) chk("timeout.at4",    {31'd0, MEM_ERR}, 32'd1);
    end
    idle();
    do_cycle("timeout_after");
    chk("timeout.sticky", {31'd0, MEM_ERR}, 32'd1);

    // Reset asserted mid-DRAIN takes effect immediately
    drive(5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 1, 0);
    do_cycle("mrd0");
    drive(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0);
    do_cycle("mrd1");
    #2 RESET_N = 1'b0;
    #1;
    model_reset();
    chk("midrst.ctrl", {25'd0, PC_HOLD, IF_ID_HOLD, ID_EX_HOLD, EX_MEM_HOLD,
                        IF_ID_FLUSH, ID_EX_FLUSH, MEM_WB_FLUSH}, 32'h07);
    chk("midrst.cnts", {20'd0, STALL_CNT, FLUSH_CNT}, 32'd0);
    chk("midrst.err",  {31'd0, MEM_ERR}, 32'd0);
    @(posedge CLK); #1;
    do_cycle("midrst_low");
    RESET_N = 1'b1;
    do_cycle("midrst_run");   // IMEM still busy: plain RUN stall, not drain

    // Random traffic
    burst = 0;
    for (int n = 0; n < 800; n++) begin
      if (burst == 0 && $urandom_range(0, 24) == 0) burst = $urandom_range(1, 7);
      drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 6) == 0), 1'($urandom_range(0, 2) == 0),
            1'(burst > 0));
      if (burst > 0) burst--;
      do_cycle("rand");
    end
    chk("rand.stall_sat", {26'd0, STALL_CNT}, SAT);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
